// File: rtl/audio_pkg.sv
// Shared audio definitions for the channel mixer and its PWM DAC.
//   mix_state_e      : mixer sequencing states (idle, accumulate, output).
//   DEFAULT_SAMPLE_WIDTH : default width of one unsigned channel sample.
//   ATTEN_WIDTH      : width of one per-channel attenuation (right-shift) field.
//   acc_width()      : accumulator width that holds the sum of num_ch samples.
package audio_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StOutput
  } mix_state_e;

  localparam int unsigned DEFAULT_SAMPLE_WIDTH = 9;
  localparam int unsigned ATTEN_WIDTH          = 2;

  // The sum of num_ch values of sample_w bits never needs more than this.
  function automatic int unsigned acc_width(input int unsigned sample_w,
                                            input int unsigned num_ch);
    return sample_w + $clog2(num_ch);
  endfunction

endpackage

// File: rtl/pwm_dac.sv
// PWM DAC: free-running WIDTH-bit counter, level register and comparator.
// Only built with CHANNEL_MIXER_PWM_EN defined; the mixer is its sole user.
//   i_clk   : clock
//   i_rst   : synchronous active-high reset
//   i_level : requested level, sampled only at the end of a PWM period
//   o_pwm   : registered PWM output, duty = level / 2^WIDTH
`ifdef CHANNEL_MIXER_PWM_EN
module pwm_dac #(
  parameter int unsigned WIDTH = 10
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_level,
  output logic             o_pwm
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] level_q, level_d;
  logic             pwm_q, pwm_d;

  always_comb begin
    cnt_d   = cnt_q + WIDTH'(1);
    // Reload only on the last count so a period never mixes two levels.
    level_d = (cnt_q == '1) ? i_level : level_q;
    pwm_d   = (cnt_q < level_q);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q   <= '0;
      level_q <= '0;
      pwm_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pwm_q   <= pwm_d;
    end
  end

  assign o_pwm = pwm_q;

endmodule
`endif

// File: rtl/channel_mixer.sv
// Channel mixer: snapshots NUM_CHANNELS unsigned samples on i_sample_stb, sums them one
// channel per clock with per-channel mute and right-shift attenuation, saturates to
// OUT_WIDTH and presents a held result with a one-cycle valid pulse.
// Optional PWM output when CHANNEL_MIXER_PWM_EN is defined.
//   i_clk, i_rst  : clock, synchronous active-high reset
//   i_sample_stb  : start-of-sample strobe (one cycle)
//   i_samples     : packed channel samples, ch0 in LSBs
//   i_mute        : per-channel mute (1 = contributes 0)
//   i_atten       : per-channel right shift 0..3, ch0 in LSBs
//   o_busy        : mix in progress
//   o_mix         : held mixed sample
//   o_mix_valid   : one-cycle pulse when o_mix updates
//   o_clip        : last result was saturated
//   o_overrun     : sticky, a strobe arrived while not idle
//   o_pwm         : PWM audio pin (CHANNEL_MIXER_PWM_EN only)
module channel_mixer
  import audio_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned SAMPLE_WIDTH = DEFAULT_SAMPLE_WIDTH,
  parameter int unsigned OUT_WIDTH    = 10
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic                                i_sample_stb,
  input  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] i_samples,
  input  logic [NUM_CHANNELS-1:0]             i_mute,
  input  logic [NUM_CHANNELS*ATTEN_WIDTH-1:0] i_atten,
  output logic                                o_busy,
  output logic [OUT_WIDTH-1:0]                o_mix,
  output logic                                o_mix_valid,
  output logic                                o_clip,
  output logic                                o_overrun
`ifdef CHANNEL_MIXER_PWM_EN
  ,
  output logic                                o_pwm
`endif
);

  localparam int unsigned AccW = acc_width(SAMPLE_WIDTH, NUM_CHANNELS);
  localparam int unsigned IdxW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int unsigned CmpW = (AccW > OUT_WIDTH) ? AccW : OUT_WIDTH;

  mix_state_e state_q, state_d;

  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] samples_q, samples_d;
  logic [NUM_CHANNELS-1:0]              mute_q, mute_d;
  logic [NUM_CHANNELS*ATTEN_WIDTH-1:0]  atten_q, atten_d;
  logic [AccW-1:0]                      acc_q, acc_d;
  logic [IdxW-1:0]                      idx_q, idx_d;
  logic                                 busy_q, busy_d;
  logic [OUT_WIDTH-1:0]                 mix_q, mix_d;
  logic                                 valid_q, valid_d;
  logic                                 clip_q, clip_d;
  logic                                 overrun_q, overrun_d;

  logic [SAMPLE_WIDTH-1:0] cur_sample;
  logic [ATTEN_WIDTH-1:0]  cur_atten;
  logic [AccW-1:0]         contrib;
  logic [AccW-1:0]         acc_sum;
  logic [CmpW-1:0]         acc_ext;
  logic                    sat;

  always_comb begin
    state_d   = state_q;
    samples_d = samples_q;
    mute_d    = mute_q;
    atten_d   = atten_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    busy_d    = busy_q;
    mix_d     = mix_q;
    valid_d   = 1'b0;
    clip_d    = clip_q;
    overrun_d = overrun_q;

    // Datapath works only from the shadow copies taken at the strobe.
    cur_sample = samples_q[int'(idx_q)*SAMPLE_WIDTH +: SAMPLE_WIDTH];
    cur_atten  = atten_q[int'(idx_q)*ATTEN_WIDTH +: ATTEN_WIDTH];
    contrib    = mute_q[idx_q] ? '0 : AccW'(cur_sample >> cur_atten);
    acc_sum    = acc_q + contrib;
    acc_ext    = CmpW'(acc_sum);
    sat        = (acc_ext > CmpW'({OUT_WIDTH{1'b1}}));

    // Includes the output cycle: a strobe there is dropped too.
    if (i_sample_stb && (state_q != StIdle)) begin
      overrun_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (i_sample_stb) begin
          samples_d = i_samples;
          mute_d    = i_mute;
          atten_d   = i_atten;
          acc_d     = '0;
          idx_d     = '0;
          busy_d    = 1'b1;
          state_d   = StAccum;
        end
      end
      StAccum: begin
        acc_d = acc_sum;
        idx_d = idx_q + IdxW'(1);
        if (idx_q == IdxW'(NUM_CHANNELS - 1)) begin
          // Result is registered while entering StOutput so valid lands in that cycle.
          state_d = StOutput;
          busy_d  = 1'b0;
          valid_d = 1'b1;
          clip_d  = sat;
          mix_d   = sat ? {OUT_WIDTH{1'b1}} : acc_ext[OUT_WIDTH-1:0];
        end
      end
      StOutput: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= StIdle;
      samples_q <= '0;
      mute_q    <= '0;
      atten_q   <= '0;
      acc_q     <= '0;
      idx_q     <= '0;
      busy_q    <= 1'b0;
      mix_q     <= '0;
      valid_q   <= 1'b0;
      clip_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      samples_q <= samples_d;
      mute_q    <= mute_d;
      atten_q   <= atten_d;
      acc_q     <= acc_d;
      idx_q     <= idx_d;
      busy_q    <= busy_d;
      mix_q     <= mix_d;
      valid_q   <= valid_d;
      clip_q    <= clip_d;
      overrun_q <= overrun_d;
    end
  end

  assign o_busy      = busy_q;
  assign o_mix       = mix_q;
  assign o_mix_valid = valid_q;
  assign o_clip      = clip_q;
  assign o_overrun   = overrun_q;

`ifdef CHANNEL_MIXER_PWM_EN
  pwm_dac #(
    .WIDTH (OUT_WIDTH)
  ) u_pwm_dac (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_level (mix_q),
    .o_pwm   (o_pwm)
  );
`endif

endmodule

// File: tb/tb_channel_mixer.sv
// Self-checking bench for channel_mixer (default parameters: 4 channels, 9-bit samples,
// 10-bit output). Expected mix results are queued when a strobe is driven and popped
// by a monitor when o_mix_valid pulses.
module tb_channel_mixer;

  logic        clk;
  logic        i_rst;
  logic        i_sample_stb;
  logic [35:0] i_samples;
  logic [3:0]  i_mute;
  logic [7:0]  i_atten;
  logic        o_busy;
  logic [9:0]  o_mix;
  logic        o_mix_valid;
  logic        o_clip;
  logic        o_overrun;
`ifdef CHANNEL_MIXER_PWM_EN
  logic        o_pwm;
`endif

  int vectors;
  int miscompares;
  int valid_count;
  logic [10:0] sb[$];  // {clip, mix}

  channel_mixer #(
    .NUM_CHANNELS (4),
    .SAMPLE_WIDTH (9),
    .OUT_WIDTH    (10)
  ) dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_sample_stb (i_sample_stb),
    .i_samples    (i_samples),
    .i_mute       (i_mute),
    .i_atten      (i_atten),
    .o_busy       (o_busy),
    .o_mix        (o_mix),
    .o_mix_valid  (o_mix_valid),
    .o_clip       (o_clip),
    .o_overrun    (o_overrun)
`ifdef CHANNEL_MIXER_PWM_EN
    ,
    .o_pwm        (o_pwm)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: sum of unmuted samples shifted right by their attenuation, saturated.
  function automatic logic [10:0] model(input logic [35:0] s, input logic [3:0] m,
                                        input logic [7:0] a);
    int sum;
    logic [8:0] smp;
    logic [1:0] sh;
    sum = 0;
    for (int c = 0; c < 4; c++) begin
      smp = s[c*9 +: 9];
      sh  = a[c*2 +: 2];
      if (!m[c]) sum += int'(smp) >> sh;
    end
    if (sum > 1023) return {1'b1, 10'd1023};
    return {1'b0, sum[9:0]};
  endfunction

  // Scoreboard monitor: compare each valid pulse against the oldest queued result.
  always @(negedge clk) begin
    logic [10:0] e;
    if (o_mix_valid === 1'b1) begin
      valid_count++;
      if (sb.size() == 0) begin
        check("unexpected_valid", 32'(o_mix), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check("sb_mix", 32'(o_mix), 32'(e[9:0]));
        check("sb_clip", 32'(o_clip), 32'(e[10]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Strobe with the given inputs and check the full busy/valid timeline to T+6.
  task automatic run_mix(input string tag, input logic [35:0] s, input logic [3:0] m,
                         input logic [7:0] a);
    logic [10:0] e;
    e = model(s, m, a);
    i_samples    = s;
    i_mute       = m;
    i_atten      = a;
    i_sample_stb = 1'b1;
    sb.push_back(e);
    step();
    i_sample_stb = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("%s_busy_T%0d", tag, k), 32'(o_busy), 32'd1);
      check($sformatf("%s_valid_T%0d", tag, k), 32'(o_mix_valid), 32'd0);
      step();
    end
    check($sformatf("%s_valid_T5", tag), 32'(o_mix_valid), 32'd1);
    check($sformatf("%s_busy_T5", tag), 32'(o_busy), 32'd0);
    step();
    check($sformatf("%s_valid_T6", tag), 32'(o_mix_valid), 32'd0);
    check($sformatf("%s_mix_held", tag), 32'(o_mix), 32'(e[9:0]));
    check($sformatf("%s_clip_held", tag), 32'(o_clip), 32'(e[10]));
  endtask

  initial begin
    int vc0;
    int hi;
    vectors      = 0;
    miscompares  = 0;
    valid_count  = 0;
    i_rst        = 1'b1;
    i_sample_stb = 1'b0;
    i_samples    = '0;
    i_mute       = '0;
    i_atten      = '0;
    step();
    step();
    i_rst = 1'b0;

    // Reset state.
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_mix", 32'(o_mix), 32'd0);
    check("rst_valid", 32'(o_mix_valid), 32'd0);
    check("rst_clip", 32'(o_clip), 32'd0);
    check("rst_overrun", 32'(o_overrun), 32'd0);
    step();

    // Basic sum, saturation, return to zero, mute/attenuation.
    run_mix("basic", {9'd15, 9'd15, 9'd15, 9'd15}, 4'b0000, 8'h00);
    run_mix("sat", {9'd511, 9'd511, 9'd511, 9'd511}, 4'b0000, 8'h00);
    step();
    check("clip_hold", 32'(o_clip), 32'd1);
    run_mix("zero", {36{1'b0}}, 4'b0000, 8'h00);
    run_mix("mute_att", {9'd0, 9'd8, 9'd200, 9'd100}, 4'b0010, 8'b00_11_00_10);
    check("no_overrun_yet", 32'(o_overrun), 32'd0);

    // Snapshot and overrun: live inputs change after the strobe, second strobe dropped.
    vc0          = valid_count;
    i_samples    = {9'd10, 9'd10, 9'd10, 9'd10};
    i_mute       = '0;
    i_atten      = '0;
    i_sample_stb = 1'b1;
    sb.push_back(model(i_samples, i_mute, i_atten));
    step();  // T+1
    i_sample_stb = 1'b0;
    i_samples    = {9'd500, 9'd500, 9'd500, 9'd500};
    step();  // T+2
    i_sample_stb = 1'b1;
    step();  // T+3
    i_sample_stb = 1'b0;
    check("ovr_set", 32'(o_overrun), 32'd1);
    check("ovr_busy", 32'(o_busy), 32'd1);
    step();
    step();  // T+5
    check("ovr_valid_T5", 32'(o_mix_valid), 32'd1);
    for (int k = 0; k < 10; k++) step();
    check("ovr_one_pulse", 32'(valid_count - vc0), 32'd1);
    check("ovr_sticky", 32'(o_overrun), 32'd1);
    check("ovr_mix", 32'(o_mix), 32'd40);

    // Reset mid-mix: aborted, no pulse, outputs back to reset values.
    vc0          = valid_count;
    i_samples    = {9'd7, 9'd7, 9'd7, 9'd7};
    i_sample_stb = 1'b1;
    step();  // T+1
    i_sample_stb = 1'b0;
    step();  // T+2
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    check("rmid_busy", 32'(o_busy), 32'd0);
    check("rmid_mix", 32'(o_mix), 32'd0);
    check("rmid_overrun", 32'(o_overrun), 32'd0);
    check("rmid_clip", 32'(o_clip), 32'd0);
    for (int k = 0; k < 8; k++) step();
    check("rmid_no_pulse", 32'(valid_count - vc0), 32'd0);
    run_mix("after_rst", {9'd1, 9'd2, 9'd3, 9'd4}, 4'b0000, 8'h00);

    // Back-to-back: strobe in the valid cycle is dropped, next cycle's strobe is taken.
    vc0          = valid_count;
    i_samples    = {9'd3, 9'd3, 9'd3, 9'd3};
    i_sample_stb = 1'b1;
    sb.push_back(model(i_samples, i_mute, i_atten));
    step();
    i_sample_stb = 1'b0;
    for (int k = 0; k < 4; k++) step();  // T+5
    check("b2b_valid", 32'(o_mix_valid), 32'd1);
    i_samples    = {9'd100, 9'd100, 9'd100, 9'd100};
    i_sample_stb = 1'b1;
    step();  // T+6
    check("b2b_dropped_busy", 32'(o_busy), 32'd0);
    check("b2b_overrun", 32'(o_overrun), 32'd1);
    i_samples = {9'd5, 9'd5, 9'd5, 9'd5};
    sb.push_back(model(i_samples, i_mute, i_atten));
    step();  // T+7
    i_sample_stb = 1'b0;
    check("b2b_accept_busy", 32'(o_busy), 32'd1);
    for (int k = 0; k < 4; k++) step();  // T+11
    check("b2b_valid2", 32'(o_mix_valid), 32'd1);
    step();
    check("b2b_mix", 32'(o_mix), 32'd20);
    check("b2b_pulses", 32'(valid_count - vc0), 32'd2);

`ifdef CHANNEL_MIXER_PWM_EN
    // PWM duty: level 256 gives 256 high cycles per 1024-cycle period, level 0 none.
    run_mix("pwm256", {9'd64, 9'd64, 9'd64, 9'd64}, 4'b0000, 8'h00);
    for (int k = 0; k < 2100; k++) step();
    hi = 0;
    for (int k = 0; k < 1024; k++) begin
      if (o_pwm === 1'b1) hi++;
      step();
    end
    check("pwm_duty_256", 32'(hi), 32'd256);
    run_mix("pwm0", {36{1'b0}}, 4'b0000, 8'h00);
    for (int k = 0; k < 2100; k++) step();
    hi = 0;
    for (int k = 0; k < 1024; k++) begin
      if (o_pwm === 1'b1) hi++;
      step();
    end
    check("pwm_duty_0", 32'(hi), 32'd0);
`else
    hi = 0;
`endif

    step();
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
